// File: rtl/add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit adder slice per cycle, LSW first.
// Optional signed-overflow output is enabled by defining ADD_SEQ_OVF_EN.
module add_seq #(
    parameter int NWORDS = 4,
    localparam int W = 16 * NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic [IW-1:0] idx_reg;
    logic          cout_reg;

    logic          accept;
    logic          step;
    logic          last;

    logic [15:0]   a_words [NWORDS];
    logic [15:0]   b_words [NWORDS];
    logic [15:0]   res_word_reg [NWORDS];

    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic [15:0]   add_sum;
    logic          add_co;

    assign last = (idx_reg == LAST_IDX);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // No same-cycle accept here: in_ready only returns in IDLE.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice selection and the shared 16-bit adder
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign a_words[gi] = a_reg[16*gi +: 16];
            assign b_words[gi] = b_reg[16*gi +: 16];
        end
    endgenerate

    assign add_a = a_words[idx_reg];
    assign add_b = b_words[idx_reg];

    always_comb begin : add16
        logic [16:0] full;
        full    = {1'b0, add_a} + {1'b0, add_b} + {16'd0, carry_reg};
        add_sum = full[15:0];
        add_co  = full[16];
    end

    // ------------------------------------------------------------------
    // Operand latch, carry chain and index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            if (accept) begin
                // Subtraction reuses the adder as A + ~B + 1.
                a_reg     <= op_a;
                b_reg     <= sub ? ~op_b : op_b;
                carry_reg <= sub;
                idx_reg   <= '0;
            end
            if (step) begin
                carry_reg <= add_co;
                if (last) begin
                    cout_reg <= add_co;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    // Each result slice is its own register, written only on its turn.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_result
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_word_reg[gi] <= '0;
                end else if (step && (idx_reg == IW'(gi))) begin
                    res_word_reg[gi] <= add_sum;
                end
            end
            assign result[16*gi +: 16] = res_word_reg[gi];
        end
    endgenerate

    assign cout = cout_reg;

`ifdef ADD_SEQ_OVF_EN
    logic ovf_reg;

    // Captured on the final slice, using that slice's fresh sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (step && last) begin
            ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq with a queue scoreboard of expected results.
module tb_add_seq;

    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    add_seq #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
`ifdef ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_ovf(input string tag, input logic want);
`ifdef ADD_SEQ_OVF_EN
        check(tag, ovf, want);
`endif
    endtask

    // Drive an operation, wait for acceptance, push the arithmetic expectation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int           n;
        logic [W:0]   full;
        logic [W-1:0] beff;
        exp_t         e;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        n        = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_wait", (n < 50), 1);
        @(posedge clk);
        #1;
        beff  = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, s};
        e.res = full[W-1:0];
        e.co  = full[W];
        e.ov  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
        sb.push_back(e);
        // Scramble the operand bus: it must only be sampled at accept.
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
        sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, NWORDS);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: got empty queue expected one entry", tag);
        end
        if (sb.size() != 0) begin
            last_exp = sb.pop_front();
            check({tag, "_result"}, result, last_exp.res);
            check({tag, "_cout"}, cout, last_exp.co);
            check_ovf({tag, "_ovf"}, last_exp.ov);
        end
        $display("op %s: result=%h cout=%b latency=%0d", tag, result, cout, lat);
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, out_valid, 0);
        check({tag, "_hs_in_ready"}, in_ready, 1);
    endtask

    initial begin
        exp_t dropped;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check_ovf("rst_ovf", 1'b0);

        // Carry across a slice boundary
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_result("t2");
        check("t2_const_result", result, 64'h0000_0000_0001_0000);
        check("t2_const_cout", cout, 0);
        finish_handshake("t2");

        // Full-width carry out, then signed overflow
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result("t3a");
        check("t3a_const_result", result, 64'h0);
        check("t3a_const_cout", cout, 1);
        check_ovf("t3a_const_ovf", 1'b0);
        finish_handshake("t3a");
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result("t3b");
        check("t3b_const_result", result, 64'h8000_0000_0000_0000);
        check_ovf("t3b_const_ovf", 1'b1);
        finish_handshake("t3b");

        // Subtraction with and without borrow
        start_op(64'd5, 64'd7, 1'b1);
        wait_result("t4a");
        check("t4a_const_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t4a_const_cout", cout, 0);
        check_ovf("t4a_const_ovf", 1'b0);
        finish_handshake("t4a");
        start_op(64'd7, 64'd5, 1'b1);
        wait_result("t4b");
        check("t4b_const_result", result, 64'd2);
        check("t4b_const_cout", cout, 1);
        finish_handshake("t4b");

        // Back-pressure in DONE while a new op is offered
        start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        wait_result("t5a");
        in_valid = 1'b1;
        op_a     = 64'h8000_0000_0000_0001;
        op_b     = 64'h0000_0000_0000_0002;
        sub      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_out_valid", out_valid, 1);
            check("t5_hold_in_ready", in_ready, 0);
            check("t5_hold_result", result, last_exp.res);
            check("t5_hold_cout", cout, last_exp.co);
        end
        finish_handshake("t5a");
        start_op(64'h8000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1);
        wait_result("t5b");
        finish_handshake("t5b");

        // Reset in the middle of RUN discards the op
        start_op(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dropped = sb.pop_back();
        check("t6_in_ready", in_ready, 1);
        check("t6_out_valid", out_valid, 0);
        check("t6_result", result, 0);
        check("t6_cout", cout, 0);
        start_op(64'h0001_0002_0003_0004, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_result("t6b");
        finish_handshake("t6b");

        // Random mix
        for (int i = 0; i < 6; i++) begin
            start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_result("rnd");
            finish_handshake("rnd");
        end

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
